// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD requester: FSM state encoding,
// default parameter values and the response record seen by a consumer.
package gcd_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_ID_W    = 4;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } gcd_state_t;

  // Response record at the default widths; packs as {result, id, timeout}.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] result;
    logic [DEFAULT_ID_W-1:0]  id;
    logic                     timeout;
  } gcd_rsp_t;

endpackage

// File: rtl/gcd_req_watchdog.sv
// WAIT-phase watchdog: cleared before each operation, counts enabled cycles
// and flags expiry on the TIMEOUT-th counted cycle.
module gcd_req_watchdog
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      // Holding at LAST keeps the counter from wrapping; expiry exits WAIT anyway.
      count <= count + CW'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/gcd_requester.sv
// Request/response front end for an external GCD core: accepts one tagged
// request, starts the core, waits with a watchdog and returns the result or an abort.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = DEFAULT_ID_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [ID_W-1:0]  req_id,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_timeout,
  output logic             busy
);

  gcd_state_t state_q, state_d;
  logic       drain_pending;
  logic       expire;

  gcd_req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_ISSUE),
    .enable (state_q == ST_WAIT),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid)            state_d = ST_ISSUE;
      ST_ISSUE:                           state_d = ST_WAIT;
      ST_WAIT:  if (core_done || expire)  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready)            state_d = drain_pending ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (core_done)            state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_a        <= '0;
      core_b        <= '0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_timeout   <= 1'b0;
      drain_pending <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        core_a <= req_a;
        core_b <= req_b;
        rsp_id <= req_id;
      end
      // core_done is only sampled in WAIT and DRAIN, so a stale done is never captured.
      if (state_q == ST_WAIT) begin
        if (core_done) begin
          rsp_result  <= core_result;
          rsp_timeout <= 1'b0;
        end else if (expire) begin
          rsp_result    <= '0;
          rsp_timeout   <= 1'b1;
          drain_pending <= 1'b1;
        end
      end
      if (state_q == ST_DRAIN && core_done) drain_pending <= 1'b0;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign core_start = (state_q == ST_ISSUE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a subtractive GCD core model and a
// controllable done/result stub for the watchdog scenarios.
module tb_gcd_requester;
  import gcd_pkg::*;

  localparam int WIDTH   = DEFAULT_WIDTH;
  localparam int ID_W    = DEFAULT_ID_W;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [ID_W-1:0]  req_id = '0;
  logic             core_start;
  logic [WIDTH-1:0] core_a, core_b;
  logic [WIDTH-1:0] core_result;
  logic             core_done;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_result;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_timeout;
  logic             busy;

  logic             use_stub = 1'b0;
  logic             stub_done = 1'b0;
  logic [WIDTH-1:0] stub_result = '0;

  int n_pass = 0;
  int n_total = 0;
  int start_cnt = 0;
  int start_overlap = 0;

  always #5 clk = ~clk;

  gcd_requester #(.WIDTH(WIDTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_id      (req_id),
    .core_start  (core_start),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_result (core_result),
    .core_done   (core_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_id      (rsp_id),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  // Behavioural subtractive GCD core: loads on start, clears done, holds done until next start.
  logic [WIDTH-1:0] mx, my, m_res;
  logic             m_done, m_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mx <= '0; my <= '0; m_res <= '0; m_done <= 1'b0; m_busy <= 1'b0;
    end else if (core_start) begin
      if (m_busy) start_overlap <= start_overlap + 1;
      mx <= core_a; my <= core_b; m_done <= 1'b0; m_busy <= 1'b1;
    end else if (m_busy) begin
      if (mx == '0) begin
        m_res <= my; m_done <= 1'b1; m_busy <= 1'b0;
      end else if (my == '0 || mx == my) begin
        m_res <= mx; m_done <= 1'b1; m_busy <= 1'b0;
      end else if (mx > my) begin
        mx <= mx - my;
      end else begin
        my <= my - mx;
      end
    end
  end

  always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

  assign core_done   = use_stub ? stub_done   : m_done;
  assign core_result = use_stub ? stub_result : m_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one request and returns just after the accepting edge.
  task automatic send_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [ID_W-1:0] id, output int waited);
    req_a = a; req_b = b; req_id = id; req_valid = 1'b1; waited = 0;
    while (!req_ready && waited < 64) begin
      tick();
      waited++;
    end
    if (req_ready) begin
      tick();
    end else begin
      n_total++;
      $display("FAIL req_accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waited);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 64) begin
      tick();
      lat++;
    end
    if (!rsp_valid) begin
      n_total++;
      $display("FAIL rsp_wait_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    reset = 1'b0;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b expected 1", req_ready); else n_pass++;
    n_total++; if ({busy, core_start, rsp_valid} !== 3'b000)
      $display("FAIL reset_flags: busy/start/valid got %b expected 000", {busy, core_start, rsp_valid}); else n_pass++;
    n_total++; if ({core_a, core_b} !== '0) $display("FAIL reset_core_ops: got %0h/%0h expected 0/0", core_a, core_b); else n_pass++;
    n_total++; if ({rsp_result, rsp_id, rsp_timeout} !== '0)
      $display("FAIL reset_rsp: got %0h/%0h/%0b expected 0/0/0", rsp_result, rsp_id, rsp_timeout); else n_pass++;
  endtask

  task automatic test_basic();
    int w, lat, s0;
    s0 = start_cnt;
    send_req(48, 18, 3, w);
    wait_rsp(lat);
    n_total++; if (start_cnt - s0 !== 1) $display("FAIL basic_start_pulses: got %0d expected 1", start_cnt - s0); else n_pass++;
    n_total++; if ({rsp_result, rsp_id, rsp_timeout} !== {32'd6, 4'd3, 1'b0})
      $display("FAIL basic_rsp: got %0d/%0d/%0b expected 6/3/0", rsp_result, rsp_id, rsp_timeout); else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_total++; if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL basic_return_idle: valid/ready got %b expected 01", {rsp_valid, req_ready}); else n_pass++;
  endtask

  task automatic test_min_latency_hold();
    int w, lat, bad;
    send_req(0, 7, 5, w);
    wait_rsp(lat);
    n_total++; if (lat !== 3) $display("FAIL min_latency: got %0d cycles expected 3", lat); else n_pass++;
    n_total++; if ({rsp_result, rsp_id, rsp_timeout} !== {32'd7, 4'd5, 1'b0})
      $display("FAIL min_rsp: got %0d/%0d/%0b expected 7/5/0", rsp_result, rsp_id, rsp_timeout); else n_pass++;
    // A competing request is offered while the response is back-pressured.
    req_a = 99; req_b = 98; req_id = 1; req_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if ({rsp_valid, rsp_result, rsp_id, rsp_timeout, req_ready} !== {1'b1, 32'd7, 4'd5, 1'b0, 1'b0}
          || core_a !== '0 || core_b !== 32'd7) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL hold_stable: %0d unstable cycles, expected 0", bad); else n_pass++;
    req_valid = 1'b0;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_total++; if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL hold_release: valid/ready got %b expected 01", {rsp_valid, req_ready}); else n_pass++;
  endtask

  task automatic test_timeout_drain();
    int w, lat, bad;
    use_stub = 1'b1; stub_done = 1'b0; stub_result = 32'hdead;
    send_req(100, 75, 9, w);
    wait_rsp(lat);
    n_total++; if (lat !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 1); else n_pass++;
    n_total++; if ({rsp_result, rsp_id, rsp_timeout} !== {32'd0, 4'd9, 1'b1})
      $display("FAIL timeout_rsp: got %0h/%0d/%0b expected 0/9/1", rsp_result, rsp_id, rsp_timeout); else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    bad = 0;
    repeat (10) begin
      if (req_ready || !busy || core_start || rsp_valid) bad++;
      tick();
    end
    n_total++; if (bad !== 0) $display("FAIL drain_hold: %0d cycles left DRAIN early, expected 0", bad); else n_pass++;
    stub_done = 1'b1;
    tick();
    n_total++; if ({req_ready, busy} !== 2'b10)
      $display("FAIL drain_exit: ready/busy got %b expected 10", {req_ready, busy}); else n_pass++;
    use_stub = 1'b0; stub_done = 1'b0;
    send_req(9, 6, 4, w);
    n_total++; if (w !== 0) $display("FAIL drain_next_accept: waited %0d cycles expected 0", w); else n_pass++;
    wait_rsp(lat);
    n_total++; if ({rsp_result, rsp_id, rsp_timeout} !== {32'd3, 4'd4, 1'b0})
      $display("FAIL drain_next_rsp: got %0d/%0d/%0b expected 3/4/0", rsp_result, rsp_id, rsp_timeout); else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_done_at_expiry();
    int w;
    use_stub = 1'b1; stub_done = 1'b0; stub_result = 32'd42;
    send_req(9, 6, 6, w);
    repeat (TIMEOUT) tick();
    n_total++; if ({rsp_valid, busy} !== 2'b01)
      $display("FAIL expiry_pre: valid/busy got %b expected 01", {rsp_valid, busy}); else n_pass++;
    stub_done = 1'b1;
    tick();
    n_total++; if ({rsp_valid, rsp_result, rsp_id, rsp_timeout} !== {1'b1, 32'd42, 4'd6, 1'b0})
      $display("FAIL expiry_done_wins: got %0b/%0d/%0d/%0b expected 1/42/6/0", rsp_valid, rsp_result, rsp_id, rsp_timeout);
    else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_total++; if (req_ready !== 1'b1) $display("FAIL expiry_no_drain: req_ready got %0b expected 1", req_ready); else n_pass++;
    stub_done = 1'b0; use_stub = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int w, lat, bad;
    use_stub = 1'b1; stub_done = 1'b0;
    send_req(5, 3, 7, w);
    repeat (4) tick();
    n_total++; if (busy !== 1'b1) $display("FAIL midreset_busy: got %0b expected 1", busy); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if ({busy, core_start, rsp_valid, core_a, core_b, rsp_result, rsp_id, rsp_timeout} !== '0)
      $display("FAIL midreset_outputs: busy=%0b a=%0h b=%0h result=%0h id=%0h timeout=%0b expected all 0",
               busy, core_a, core_b, rsp_result, rsp_id, rsp_timeout);
    else n_pass++;
    tick();
    reset = 1'b0;
    n_total++; if (req_ready !== 1'b1) $display("FAIL midreset_ready: got %0b expected 1", req_ready); else n_pass++;
    bad = 0;
    repeat (TIMEOUT + 4) begin
      tick();
      if (rsp_valid || busy || core_start) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL midreset_silent: %0d active cycles expected 0", bad); else n_pass++;
    use_stub = 1'b0;
    send_req(12, 8, 2, w);
    wait_rsp(lat);
    n_total++; if ({rsp_result, rsp_id, rsp_timeout} !== {32'd4, 4'd2, 1'b0})
      $display("FAIL midreset_fresh: got %0d/%0d/%0b expected 4/2/0", rsp_result, rsp_id, rsp_timeout); else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ta [3];
    logic [WIDTH-1:0] tb [3];
    gcd_rsp_t         exp [3];
    int w, lat, s0;
    ta = '{32'd21, 32'd35, 32'd17};
    tb = '{32'd14, 32'd10, 32'd5};
    exp[0] = '{result: 32'd7, id: 4'd1, timeout: 1'b0};
    exp[1] = '{result: 32'd5, id: 4'd2, timeout: 1'b0};
    exp[2] = '{result: 32'd1, id: 4'd3, timeout: 1'b0};
    s0 = start_cnt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_req(ta[i], tb[i], ID_W'(i + 1), w);
      if (i > 0) begin
        n_total++; if (w !== 1) $display("FAIL b2b_accept_%0d: waited %0d cycles expected 1", i, w); else n_pass++;
      end
      wait_rsp(lat);
      n_total++; if ({rsp_result, rsp_id, rsp_timeout} !== exp[i])
        $display("FAIL b2b_rsp_%0d: got %0d/%0d/%0b expected %0d/%0d/%0b", i, rsp_result, rsp_id, rsp_timeout,
                 exp[i].result, exp[i].id, exp[i].timeout);
      else n_pass++;
    end
    tick();
    rsp_ready = 1'b0;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL b2b_final_valid: got %0b expected 0", rsp_valid); else n_pass++;
    n_total++; if (start_cnt - s0 !== 3) $display("FAIL b2b_start_count: got %0d expected 3", start_cnt - s0); else n_pass++;
    n_total++; if (start_overlap !== 0) $display("FAIL start_while_busy: got %0d expected 0", start_overlap); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_latency_hold();
    test_timeout_drain();
    test_done_at_expiry();
    test_reset_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter ID_W, default 4, request tag width.
REQ-003 Parameter TIMEOUT, default 1024, max WAIT cycles before abort; legal range 2..65535.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request offered; req_ready  out  1  request accepted when both high at an edge.
REQ-007 req_a, req_b  in  WIDTH  operands; req_id  in  ID_W  tag.
REQ-008 core_start  out  1  one-cycle start pulse to the GCD core; core_a, core_b  out  WIDTH  registered operands.
REQ-009 core_result  in  WIDTH  core result; core_done  in  1  level, held high by the core until its next start.
REQ-010 rsp_valid  out  1; rsp_ready  in  1  response handshake, transfer when both high at an edge.
REQ-011 rsp_result  out  WIDTH; rsp_id  out  ID_W; rsp_timeout  out  1  abort flag.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-014 req_ready SHALL equal (state==IDLE); no request is accepted in any other state.
REQ-015 IDLE: on req handshake, capture req_a/req_b into core_a/core_b and req_id into an id register; go to ISSUE.
REQ-016 ISSUE: core_start=1 for exactly this one cycle; go to WAIT unconditionally.
REQ-017 core_a/core_b SHALL hold stable from ISSUE until the next request is captured.
REQ-018 WAIT: watchdog counter cleared on entry, incremented once per WAIT cycle.
REQ-019 WAIT with core_done=1: latch rsp_result=core_result, rsp_timeout=0; go to RESP.
REQ-020 WAIT with core_done=0 and counter==TIMEOUT-1: latch rsp_result=0, rsp_timeout=1, set drain_pending; go to RESP.
REQ-021 core_done and watchdog expiry in the same cycle: core_done wins (normal result, rsp_timeout=0).
REQ-022 core_done is ignored in IDLE, ISSUE and RESP (no stale-done capture; the core clears done on its start edge).
REQ-023 RESP: rsp_valid=1; rsp_result/rsp_id/rsp_timeout held stable until handshake.
REQ-024 RESP handshake: go to DRAIN if drain_pending, else IDLE.
REQ-025 DRAIN: wait for core_done=1, then clear drain_pending and go to IDLE; the late result is discarded.
REQ-026 Minimum latency: request accept edge to rsp_valid high = core latency + 2 cycles.
REQ-027 Back-to-back throughput: a new request is accepted in the cycle after the response handshake.
REQ-028 Watchdog counter width = clog2(TIMEOUT); it never wraps, because expiry forces the exit from WAIT.

Reset
REQ-029 On reset: state=IDLE, core_start=0, core_a=0, core_b=0, rsp_valid=0, rsp_result=0, rsp_id=0, rsp_timeout=0, busy=0, drain_pending=0, counter=0.
REQ-030 Reset asserted in any state, including mid-WAIT, aborts the operation silently with no response; req_ready=1 in the first cycle after deassertion.

Structure
REQ-031 Shared package gcd_pkg: FSM state enum, default WIDTH/ID_W/TIMEOUT constants, response struct {result, id, timeout}.
REQ-032 One sub-module, gcd_req_watchdog: clear/enable/expire counter parameterised by TIMEOUT.
REQ-033 The GCD core is external, connected by the integrator; gcd_requester does not instantiate it.

Verification
REQ-034 Bench uses a behavioural subtractive GCD core model with the same start/done protocol.
REQ-035 req a=48, b=18, id=3 -> one core_start pulse; rsp_result=6, rsp_id=3, rsp_timeout=0.
REQ-036 req a=0, b=7 -> rsp_result=7 at minimum latency; hold rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0 throughout.
REQ-037 TIMEOUT=16, core stub never asserts done -> rsp_timeout=1, rsp_result=0 after 16 WAIT cycles; stub raises done 10 cycles later -> DRAIN exits, next req accepted one cycle after.
REQ-038 Core stub asserts done exactly on the 16th WAIT cycle (TIMEOUT=16) -> normal response, rsp_timeout=0, no DRAIN.
REQ-039 Reset pulsed mid-WAIT -> no rsp_valid; all outputs at reset values; a fresh req a=12, b=8 -> rsp_result=4.
REQ-040 Three back-to-back requests with rsp_ready=1 -> responses in order with matching ids; core_start never asserted while busy with a prior op.
